// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locking arbiter for the shared FIFO write port.
// A grant lasts until last, MAX_BURST words, or the owner drops its request.
module fifo_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   nrst_in,
    input  logic [N_REQ-1:0]       req_in,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    input  logic [N_REQ-1:0]       last_in,
    input  logic                   full_in,
    output logic [N_REQ-1:0]       ack_out,
    output logic [N_REQ-1:0]       grant_out,
    output logic                   write_out,
    output logic [WIDTH-1:0]       data_write_out,
    output logic                   busy_out
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_TOP  = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [OW-1:0]    owner_q;
    logic [OW-1:0]    owner_d;
    logic [OW-1:0]    last_owner_q;
    logic [OW-1:0]    last_owner_d;
    logic [CW-1:0]    burst_cnt_q;
    logic [CW-1:0]    burst_cnt_d;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] grant_d;

    logic [OW-1:0]    winner;
    logic             winner_ok;
    logic             owner_req;
    logic             owner_last;
    logic             accept;
    logic             release_now;

    function automatic logic [OW-1:0] wrap_add(
        input logic [OW-1:0] base,
        input int            step
    );
        int s;
        s = (int'(base) + step) % N_REQ;
        return OW'(s);
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search; walking offsets downward lets the nearest one win.
    always_comb begin
        winner    = last_owner_q;
        winner_ok = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_in[wrap_add(last_owner_q, k)]) begin
                winner    = wrap_add(last_owner_q, k);
                winner_ok = 1'b1;
            end
        end
    end

    // Zero-latency write handshake for the current owner only.
    always_comb begin
        owner_req      = 1'b0;
        owner_last     = 1'b0;
        accept         = 1'b0;
        ack_out        = '0;
        data_write_out = '0;
        if (state_q == BUSY) begin
            owner_req      = req_in[owner_q];
            owner_last     = last_in[owner_q];
            accept         = owner_req & ~full_in;
            data_write_out = data_in[int'(owner_q)*WIDTH +: WIDTH];
            if (accept) begin
                ack_out = onehot(owner_q);
            end
        end
        write_out = accept;
    end

    // A full FIFO stalls the burst but never ends it.
    assign release_now = (state_q == BUSY) &&
                         (!owner_req ||
                          (accept && (owner_last || burst_cnt_q == CNT_TOP)));

    // Next-state logic: grant in IDLE, count or release in BUSY.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        grant_d      = grant_q;
        unique case (state_q)
            IDLE: begin
                if (winner_ok) begin
                    state_d     = BUSY;
                    owner_d     = winner;
                    grant_d     = onehot(winner);
                    burst_cnt_d = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_d      = IDLE;
                    grant_d      = '0;
                    last_owner_d = owner_q;
                    burst_cnt_d  = '0;
                end else if (accept) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset leaves requester 0 at top priority.
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
            burst_cnt_q  <= '0;
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            grant_q      <= grant_d;
        end
    end

    assign grant_out = grant_q;
    assign busy_out  = (state_q == BUSY);

    a_ack_onehot: assert property (
        @(posedge clk) disable iff (!nrst_in) $onehot0(ack_out));
    a_grant_onehot: assert property (
        @(posedge clk) disable iff (!nrst_in) $onehot0(grant_out));
    a_no_write_full: assert property (
        @(posedge clk) disable iff (!nrst_in) write_out |-> !full_in);

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the write port of the asynchronous circular FIFO among N_REQ requesters, all in the FIFO write-clock domain.
- Uses round-robin arbitration with burst locking. A granted requester keeps the port until it signals last, hits MAX_BURST words, or drops its request.
- Drives the FIFO's write_in/data_write_in and observes its full_out.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- MAX_BURST, 4, maximum words accepted per grant (>=1).

Ports:
- clk  input  1  write-domain clock; same clock as the FIFO write_clk.
- nrst_in  input  1  asynchronous active-low reset.
- req_in  input  N_REQ  per-requester word-valid.
- data_in  input  N_REQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH].
- last_in  input  N_REQ  requester i marks its current word as end of burst.
- full_in  input  1  FIFO full_out.
- ack_out  output  N_REQ  one-hot; word of requester i accepted this cycle.
- grant_out  output  N_REQ  one-hot registered grant; zero when idle.
- write_out  output  1  to FIFO write_in.
- data_write_out  output  WIDTH  to FIFO data_write_in.
- busy_out  output  1  high while in BUSY.

Behaviour:
- Reset (nrst_in low, asynchronous):
  - state=IDLE, grant_out=0, busy_out=0, burst_cnt=0.
  - last_owner=N_REQ-1, so requester 0 has top priority after reset.
  - Combinational outputs evaluate to write_out=0, ack_out=0, data_write_out=0.
- States: IDLE, BUSY. Internal registers: owner (clog2(N_REQ) bits), last_owner, burst_cnt (clog2(MAX_BURST+1) bits).
- IDLE, any req_in high:
  - Winner is the first requester with req high, searching last_owner+1, +2, ... modulo N_REQ.
  - Next edge: owner=winner, grant_out=onehot(winner), burst_cnt=0, state=BUSY.
  - Arbitration latency is 1 cycle. No write ever happens in IDLE.
- IDLE, req_in=0: remain in IDLE.
- BUSY, combinational outputs (zero-latency handshake):
  - write_out = req_in[owner] & ~full_in.
  - data_write_out = data_in[owner] (0 when not BUSY).
  - ack_out = write_out ? onehot(owner) : 0.
  - A requester holds req/data/last stable until it sees ack; a new word may follow on the next cycle.
- BUSY, release conditions, evaluated at the clock edge:
  - (a) accept with last_in[owner]=1;
  - (b) accept with burst_cnt+1==MAX_BURST;
  - (c) req_in[owner]=0.
  - On release: state=IDLE, grant_out=0, last_owner=owner, burst_cnt=0.
  - Otherwise burst_cnt increments on each accept.
- full_in high in BUSY: no write, no ack, burst_cnt holds, grant held indefinitely. A full FIFO never causes a release.
- full_in and req both high: no write. The word is retried every cycle until full_in drops.
- Grant release and re-arbitration always cost one IDLE cycle. Back-to-back bursts are therefore separated by exactly 1 idle cycle.
- Requests from non-owners are ignored while BUSY; no ack and no data leakage.
- N_REQ=1 degenerates to burst-limited passthrough with a 1-cycle gap per burst.
- Reset asserted mid-burst: immediate return to the reset values. write_out drops combinationally in the same cycle. No partial state survives.
- Invariants:
  - ack_out and grant_out are at most one-hot.
  - write_out=1 implies full_in=0.
  - The number of acks per grant is <= MAX_BURST.

Test Plan:
- Reset then req_in=4'b0001, data 8'h23, last=1, full=0 → grant_out=0001 after 1 cycle. Next cycle write_out=1, data_write_out=8'h23, ack_out=0001. Then IDLE with grant_out=0.
- req_in=4'b1111 held, no last, MAX_BURST=4 → grants cycle 0,1,2,3,0. Each grant yields exactly 4 acks, with a 1-cycle gap between grants. FIFO readback order matches the sequence of acked words.
- Requester 2 bursts 8'h11, 8'h99 and sets last on the second word → exactly 2 acks, then release. Next grant goes to requester 3 if requesting, otherwise wraps to 0.
- Owner requesting, full_in=1 for 5 cycles → write_out=0 and ack_out=0 throughout, grant unchanged. After full_in drops, the held word is written exactly once.
- Owner drops req_in after 2 of 4 words → release to IDLE, no further write. Another pending requester is granted on the following cycle.
- nrst_in pulsed low mid-burst → write_out, grant_out and busy_out go to 0 immediately. After release, requester 0 wins first if requesting.
